jk_updown_counter: RTL
======================

Name: jk_updown_counter

Overview:
- Synchronous WIDTH-bit up/down counter built entirely from JK flip-flop cells.
- Contains the excitation-logic stage that generates J/K per bit and drives the JK storage bank.
- Optional prescaler slows counting for board display (LEDs / 7-seg downstream).
- Next lab stage after the single JK flip-flop: the counter is the consumer of that cell and the producer of its J/K inputs.

Parameters:
- WIDTH, 4, number of counter bits (1..8).
- PRESCALE, 1, count once every PRESCALE enabled cycles (1 = every cycle; range 1..2^16-1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count enable; gates both the prescaler and counting.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on the counting edge.
- load  input  1  synchronous parallel load request.
- load_value  input  WIDTH  value written to q on load.
- q  output  WIDTH  counter state; these are the JK cell outputs.
- tick  output  1  internal count strobe (prescaler terminal), exported for chaining.
- tc  output  1  terminal count: the next tick will wrap.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset. No asynchronous paths.
- Reset (reset=1 at a rising edge):
  - q <= 0 and prescaler <= 0.
  - reset overrides load and enable.
  - tick and tc go to 0 while reset is held; tc is then re-evaluated combinationally from the state.
- Prescaler:
  - Counter psc, width clog2(PRESCALE) (minimum 1 bit).
  - When enable=1: psc increments, wrapping from PRESCALE-1 to 0.
  - When enable=0: psc holds.
  - tick = enable & (psc == PRESCALE-1), combinational.
  - With PRESCALE=1, tick = enable.
- Priority per edge: reset > load > tick counting > hold.
- Load:
  - On load=1, q <= load_value on that edge, regardless of enable or tick.
  - psc <= 0 on the same edge.
  - Latency is 1 cycle.
- Count:
  - On tick=1 with load=0, q <= q+1 (up=1) or q-1 (up=0), modulo 2^WIDTH.
  - Wrap-around: up from 2^WIDTH-1 gives 0; down from 0 gives 2^WIDTH-1.
  - Latency: q updates on the edge where tick=1.
- Hold: with no reset, load or tick, q is unchanged.
- Excitation (must be realised as J/K per bit, not as q+1):
  - Count mode:
    - T0 = 1.
    - Ti = AND of q[i-1:0] for up; AND of ~q[i-1:0] for down.
    - J_i = K_i = Ti & tick.
  - Load mode: J_i = load_value[i], K_i = ~load_value[i].
  - Hold: J_i = K_i = 0.
- tc:
  - tc = enable & ((up & q == all-ones) | (~up & q == 0)).
  - tc is combinational and independent of psc.
- Direction change takes effect on the next tick; no glitch handling is required (up is synchronous to clk).
- Reset mid-count: the prescaler phase is lost, and counting restarts from psc=0.

Decomposition:
- Shared package:
  - JK encoding constants: JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
  - Function clog2 for the prescaler width.
- One natural sub-module: jk_cell.
  - Ports: clk, reset, j, k, q.
  - Synchronous active-high reset to 0.
  - Next state: D = (~q & j) | (q & ~k).
  - Instantiated WIDTH times via generate.
- Excitation logic and prescaler live in the top module.

Test Plan:
- Reset then count up: reset 2 cycles, then enable=1, up=1, PRESCALE=1 for 18 cycles -> q runs 0,1,…,15,0,1; tc=1 exactly while q=15.
- Count down with wrap: load_value=4'h2, load pulse, then up=0 for 4 cycles -> q=2,1,0,15,14; tc=1 while q=0.
- Load priority: load=1 with load_value=4'hA while tick=1 and up=1, q=5 -> q=A next cycle (not 6); psc=0.
- Prescaler with PRESCALE=3, enable=1, up=1 from q=0:
  - tick pulses every 3rd cycle and q increments only on those edges: 0,0,1,1,1,2.
  - Dropping enable for 2 cycles freezes both q and psc.
- Reset mid-operation: q=7, psc=1 (PRESCALE=3), assert reset with load=1 simultaneously -> q=0, psc=0, tick=0; after release, first increment 3 cycles later.
- Direction flip at terminal: q=15, up=1, flip to up=0 one cycle before tick -> q=14, no wrap; tc tracks the new direction immediately (tc=0 at q=15, up=0).

Source files
------------

// File: rtl/jk_updown_counter_pkg.sv
// Shared definitions for the JK up/down counter: J/K excitation encodings
// and a ceiling-log2 helper used to size the prescaler.
package jk_updown_counter_pkg;

    // {J, K} excitation pairs presented to a jk_cell
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

    // Number of bits needed to hold values 0..v-1 (0 for v <= 1)
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/jk_updown_counter_jk.sv
// Single JK flip-flop storage cell.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, clears q
//   j, k  - excitation inputs (00 hold, 01 reset, 10 set, 11 toggle)
//   q     - stored bit
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    logic q_q;
    logic q_d;

    // Characteristic equation of the JK flip-flop
    always_comb begin
        q_d = (~q_q & j) | (q_q & ~k);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_updown_counter.sv
// Synchronous WIDTH-bit up/down counter built from a bank of JK cells,
// with a per-bit J/K excitation stage and an optional prescaler.
// Ports:
//   clk        - rising-edge clock
//   reset      - synchronous active-high reset (q and prescaler to 0)
//   enable     - gates both prescaler and counting
//   up         - direction, 1 = increment, 0 = decrement
//   load       - parallel load request (beats counting, loses to reset)
//   load_value - value written to q on load
//   q          - counter state, straight from the JK cells
//   tick       - prescaler terminal strobe (combinational)
//   tc         - next tick will wrap (combinational)
module jk_updown_counter
    import jk_updown_counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc
);

    localparam int unsigned PSC_BITS = clog2(PRESCALE);
    localparam int unsigned PSC_W    = (PSC_BITS < 1) ? 1 : PSC_BITS;
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(PRESCALE - 1);

    logic [PSC_W-1:0] psc_q;
    logic [PSC_W-1:0] psc_d;
    logic [WIDTH-1:0] cell_q;
    logic [WIDTH-1:0] t_up;
    logic [WIDTH-1:0] t_dn;
    logic [WIDTH-1:0] jk_j;
    logic [WIDTH-1:0] jk_k;

    // Prescaler terminal; suppressed while reset is held
    assign tick = enable & ~reset & (psc_q == PSC_LAST);

    // Prescaler next state: load realigns the phase to 0
    always_comb begin
        psc_d = psc_q;
        if (load) begin
            psc_d = '0;
        end else if (enable) begin
            psc_d = (psc_q == PSC_LAST) ? '0 : psc_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

    // Toggle conditions: bit i flips when all lower bits are 1 (up) or 0 (down)
    always_comb begin
        t_up    = '0;
        t_dn    = '0;
        t_up[0] = 1'b1;
        t_dn[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            t_up[i] = t_up[i-1] & cell_q[i-1];
            t_dn[i] = t_dn[i-1] & ~cell_q[i-1];
        end
    end

    // Per-bit J/K excitation: load forces set/reset, counting toggles
    always_comb begin
        logic [1:0] jk;
        jk_j = '0;
        jk_k = '0;
        jk   = JK_HOLD;
        for (int i = 0; i < WIDTH; i++) begin
            jk = JK_HOLD;
            if (load) begin
                jk = load_value[i] ? JK_SET : JK_RESET;
            end else if (tick && (up ? t_up[i] : t_dn[i])) begin
                jk = JK_TOGGLE;
            end
            jk_j[i] = jk[1];
            jk_k[i] = jk[0];
        end
    end

    // Storage bank
    for (genvar g = 0; g < WIDTH; g++) begin : g_cell
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (jk_j[g]),
            .k     (jk_k[g]),
            .q     (cell_q[g])
        );
    end

    assign q = cell_q;

    // Terminal count follows the current direction, independent of psc
    assign tc = enable & ~reset &
                ((up & (cell_q == '1)) | (~up & (cell_q == '0)));

endmodule
